// File: rtl/chirp_generator_if.sv
// Chirp generator control/sample bundle: DAC status, chirp request/config, status and phase stream.
// Latency: none (pure wiring bundle).
// Backpressure: dac_ready/chirp_enable act as level qualifiers; the sample stream has no ready.
`timescale 1ns/1ps
interface chirp_generator_if #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16
);
    logic               dac_ready;
    logic               chirp_init;
    logic               chirp_enable;
    logic [PHASE_W-1:0] chirp_freq_offset;
    logic [PHASE_W-1:0] chirp_tuning_coeff;
    logic [31:0]        chirp_count_max;
    logic               chirp_ready;
    logic               chirp_active;
    logic               chirp_done;
    logic               chirp_aborted;
    logic [OUT_W-1:0]   phase_out;
    logic               phase_valid;

    // Controller side: drives requests and configuration, observes status and samples.
    modport master (
        output dac_ready, chirp_init, chirp_enable,
        output chirp_freq_offset, chirp_tuning_coeff, chirp_count_max,
        input  chirp_ready, chirp_active, chirp_done, chirp_aborted,
        input  phase_out, phase_valid
    );

    // Generator side.
    modport slave (
        input  dac_ready, chirp_init, chirp_enable,
        input  chirp_freq_offset, chirp_tuning_coeff, chirp_count_max,
        output chirp_ready, chirp_active, chirp_done, chirp_aborted,
        output phase_out, phase_valid
    );
endinterface

// File: rtl/chirp_generator.sv
// Linear-FM chirp phase generator: quadratic phase accumulator driven by a ramping frequency word.
// Latency: chirp_init sampled at edge N -> first sample (phase 0) registered at edge N+1.
// Backpressure: none per sample; chirp_enable or dac_ready low mid-chirp aborts it on the next edge.
`timescale 1ns/1ps
module chirp_generator #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16
) (
    input  logic aclk,
    input  logic aresetn,
    chirp_generator_if.slave bus
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_READY = 2'd1,
        S_CHIRP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] r_freq;
    logic [PHASE_W-1:0] r_coeff;
    logic [31:0]        r_count;
    logic               r_ready;
    logic               r_active;
    logic               r_done;
    logic               r_aborted;
    logic [OUT_W-1:0]   r_phase_out;

    logic [31:0]        w_count_load;
    logic [OUT_W-1:0]   w_phase_top;

    // A zero sample count still produces one sample.
    assign w_count_load = (bus.chirp_count_max == 32'd0) ? 32'd1 : bus.chirp_count_max;
    assign w_phase_top  = r_phase[PHASE_W-1 -: OUT_W];

    // Control FSM plus datapath; every output is a register updated alongside the state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_INIT;
            r_phase     <= '0;
            r_freq      <= '0;
            r_coeff     <= '0;
            r_count     <= '0;
            r_ready     <= 1'b0;
            r_active    <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_phase_out <= '0;
        end else begin
            // Pulses and the sample stream default low; only a producing CHIRP cycle raises them.
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_active    <= 1'b0;
            r_phase_out <= '0;
            case (r_state)
                S_INIT: begin
                    r_ready <= 1'b0;
                    if (bus.dac_ready) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    // Losing the DAC outranks a start request.
                    if (!bus.dac_ready) begin
                        r_state <= S_INIT;
                        r_ready <= 1'b0;
                    end else if (bus.chirp_init && bus.chirp_enable) begin
                        r_state <= S_CHIRP;
                        r_ready <= 1'b0;
                        r_phase <= '0;
                        r_freq  <= bus.chirp_freq_offset;
                        r_coeff <= bus.chirp_tuning_coeff;
                        r_count <= w_count_load;
                    end
                end
                S_CHIRP: begin
                    // A completed sample count is a normal end even if enable drops at the same time.
                    if (r_count == 32'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (!bus.chirp_enable || !bus.dac_ready) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_active    <= 1'b1;
                        r_phase_out <= w_phase_top;
                        r_phase     <= r_phase + r_freq;
                        r_freq      <= r_freq + r_coeff;
                        r_count     <= r_count - 32'd1;
                    end
                end
                S_DONE: begin
                    if (bus.dac_ready) begin
                        r_state <= S_READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= S_INIT;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.chirp_ready   = r_ready;
    assign bus.chirp_active  = r_active;
    assign bus.phase_valid   = r_active;
    assign bus.chirp_done    = r_done;
    assign bus.chirp_aborted = r_aborted;
    assign bus.phase_out     = r_phase_out;

endmodule
